// File: rtl/dnn_infer_ctrl.sv
// Sequencer for the MNIST inference engine: soft-reset, start, wait for done
// (with timeout), sweep the 10 output scores for the argmax, hold result until ack.
module dnn_infer_ctrl #(
  parameter int DATA_WIDTH  = 11,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int TO_W        = 20
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req,
  input  logic                         ack,
  output logic                         busy,
  output logic                         res_valid,
  output logic [3:0]                   res_class,
  output logic signed [DATA_WIDTH-1:0] res_score,
  output logic                         res_err,
  output logic                         eng_reset,
  output logic                         eng_start,
  input  logic                         eng_done,
  output logic [3:0]                   eng_idx,
  input  logic signed [DATA_WIDTH-1:0] eng_out,
  output logic [2:0]                   dbg_state
);

  // Host handshake: req is a level looked at only in IDLE; ack is looked at
  // only while res_valid is high, and the cycle after it is seen we are IDLE.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLR    = 3'd1,
    S_STRT   = 3'd2,
    S_WAIT   = 3'd3,
    S_SCAN   = 3'd4,
    S_RESULT = 3'd5
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  state_t                      state_q;
  logic                        busy_q;
  logic                        valid_q;
  logic                        err_q;
  logic                        eng_reset_q;
  logic                        eng_start_q;
  logic [3:0]                  class_q;
  logic [3:0]                  idx_q;
  logic [3:0]                  arg_q;
  logic signed [DATA_WIDTH-1:0] score_q;
  logic signed [DATA_WIDTH-1:0] max_q;
  logic [TO_W-1:0]             to_cnt_q;

  logic                        take_d;
  logic [3:0]                  arg_d;
  logic signed [DATA_WIDTH-1:0] max_d;

  // Index 0 seeds the running max; later indices win only when strictly
  // greater, so ties resolve to the lowest index.
  always_comb begin
    take_d = 1'b0;
    take_d = (idx_q == 4'd0) || (eng_out > max_q);
    max_d  = take_d ? eng_out : max_q;
    arg_d  = take_d ? idx_q : arg_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      eng_reset_q <= 1'b0;
      eng_start_q <= 1'b0;
      class_q     <= 4'd0;
      idx_q       <= 4'd0;
      arg_q       <= 4'd0;
      score_q     <= '0;
      max_q       <= '0;
      to_cnt_q    <= '0;
    end else begin
      eng_reset_q <= 1'b0;
      eng_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req) begin
            state_q     <= S_CLR;
            busy_q      <= 1'b1;
            eng_reset_q <= 1'b1;
          end
        end
        S_CLR: begin
          err_q       <= 1'b0;
          max_q       <= '0;
          arg_q       <= 4'd0;
          eng_start_q <= 1'b1;
          state_q     <= S_STRT;
        end
        S_STRT: begin
          to_cnt_q <= '0;
          state_q  <= S_WAIT;
        end
        S_WAIT: begin
          to_cnt_q <= to_cnt_q + 1'b1;
          // done takes priority over a timeout landing in the same cycle
          if (eng_done) begin
            idx_q   <= 4'd0;
            state_q <= S_SCAN;
          end else if (to_cnt_q == TO_LAST) begin
            err_q   <= 1'b1;
            class_q <= 4'hF;
            score_q <= '0;
            valid_q <= 1'b1;
            state_q <= S_RESULT;
          end
        end
        S_SCAN: begin
          max_q <= max_d;
          arg_q <= arg_d;
          if (idx_q == 4'd9) begin
            class_q <= arg_d;
            score_q <= max_d;
            idx_q   <= 4'd0;
            valid_q <= 1'b1;
            state_q <= S_RESULT;
          end else begin
            idx_q <= idx_q + 4'd1;
          end
        end
        S_RESULT: begin
          if (ack) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
          idx_q   <= 4'd0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign res_valid = valid_q;
  assign res_class = class_q;
  assign res_score = score_q;
  assign res_err   = err_q;
  assign eng_reset = eng_reset_q;
  assign eng_start = eng_start_q;
  assign eng_idx   = idx_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dnn_infer_ctrl.sv
// Bench for dnn_infer_ctrl: engine model driven from a score table, cycle-level
// expectations derived from the request/done/ack timing, argmax from a plain loop.
module tb_dnn_infer_ctrl;
  localparam int DW = 11;
  localparam int T  = 8;
  localparam int TW = 4;

  logic                 clk;
  logic                 rst;
  logic                 req;
  logic                 ack;
  logic                 busy;
  logic                 res_valid;
  logic [3:0]           res_class;
  logic signed [DW-1:0] res_score;
  logic                 res_err;
  logic                 eng_reset;
  logic                 eng_start;
  logic                 eng_done;
  logic [3:0]           eng_idx;
  logic signed [DW-1:0] eng_out;
  logic [2:0]           dbg_state;

  logic signed [DW-1:0] eng_scores [16];
  logic [15:0]          exp_q [$];
  int                   n_checks;
  int                   n_fail;
  int                   cyc;

  dnn_infer_ctrl #(.DATA_WIDTH(DW), .TIMEOUT_CYC(T), .TO_W(TW)) dut (
    .clk(clk), .rst(rst), .req(req), .ack(ack), .busy(busy),
    .res_valid(res_valid), .res_class(res_class), .res_score(res_score),
    .res_err(res_err), .eng_reset(eng_reset), .eng_start(eng_start),
    .eng_done(eng_done), .eng_idx(eng_idx), .eng_out(eng_out),
    .dbg_state(dbg_state)
  );

  assign eng_out = eng_scores[eng_idx];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_fixed(input int v [10]);
    for (int i = 0; i < 10; i++) eng_scores[i] = DW'(v[i]);
  endtask

  task automatic set_random(input int mode);
    for (int i = 0; i < 10; i++) begin
      if (mode == 0) eng_scores[i] = DW'($urandom_range(0, 2047));
      else eng_scores[i] = DW'(int'($urandom_range(0, 8)) - 4);
    end
  endtask

  // Reference: packed {err, class, score}
  function automatic logic [15:0] model(input logic to);
    int best;
    if (to) return {1'b1, 4'hF, 11'd0};
    best = 0;
    for (int i = 1; i < 10; i++)
      if (int'(eng_scores[i]) > int'(eng_scores[best])) best = i;
    return {1'b0, 4'(best), eng_scores[best]};
  endfunction

  task automatic check_result(input string tag, input logic [15:0] e);
    check({tag, "_err"},   {31'b0, res_err},   {31'b0, e[15]});
    check({tag, "_class"}, {28'b0, res_class}, {28'b0, e[14:11]});
    check({tag, "_score"}, {21'b0, res_score}, {21'b0, e[10:0]});
  endtask

  // Entered during an IDLE cycle (that cycle becomes cycle 0 of the request).
  task automatic run_one(input int done_cyc, input int ack_wait, input logic req_next,
                         input int abort_idx);
    int          valid_cyc;
    int          exp_idx;
    logic        to;
    logic [15:0] e;
    to        = (done_cyc < 3) || (done_cyc > T + 2);
    valid_cyc = to ? T + 3 : done_cyc + 11;
    exp_q.push_back(model(to));
    req = 1'b1;
    cyc = 0;
    while (cyc < valid_cyc) begin
      tick();
      req      = 1'b0;
      eng_done = !to && (cyc >= done_cyc);
      exp_idx  = (!to && cyc > done_cyc && cyc <= done_cyc + 10) ? cyc - done_cyc - 1 : 0;
      check("busy", {31'b0, busy}, 32'd1);
      check("eng_reset", {31'b0, eng_reset}, {31'b0, cyc == 1});
      check("eng_start", {31'b0, eng_start}, {31'b0, cyc == 2});
      check("eng_idx", {28'b0, eng_idx}, 32'(exp_idx));
      check("res_valid", {31'b0, res_valid}, {31'b0, cyc == valid_cyc});
      if (cyc >= 2 && cyc < valid_cyc) check("res_err_clr", {31'b0, res_err}, 32'd0);
      if (abort_idx >= 0 && !to && cyc > done_cyc && exp_idx == abort_idx) begin
        rst = 1'b0;
        #1;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_valid", {31'b0, res_valid}, 32'd0);
        check("abort_idx", {28'b0, eng_idx}, 32'd0);
        check("abort_ctl", {30'b0, eng_reset, eng_start}, 32'd0);
        check_result("abort", 16'd0);
        #1;
        rst      = 1'b1;
        eng_done = 1'b0;
        void'(exp_q.pop_front());
        return;
      end
    end
    eng_done = 1'b0;
    e = exp_q.pop_front();
    check_result("result", e);
    for (int k = 0; k < ack_wait; k++) begin
      tick();
      check("hold_valid", {31'b0, res_valid}, 32'd1);
      check("hold_busy", {31'b0, busy}, 32'd1);
      check_result("hold", e);
    end
    ack = 1'b1;
    req = req_next;
    tick();
    ack = 1'b0;
    check("idle_valid", {31'b0, res_valid}, 32'd0);
    check("idle_busy", {31'b0, busy}, 32'd0);
    check("idle_eng_reset", {31'b0, eng_reset}, 32'd0);
    check_result("idle_held", e);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    rst      = 1'b0;
    req      = 1'b0;
    ack      = 1'b0;
    eng_done = 1'b0;
    for (int i = 0; i < 16; i++) eng_scores[i] = 11'sd1023;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_valid", {31'b0, res_valid}, 32'd0);
    check("rst_ctl", {30'b0, eng_reset, eng_start}, 32'd0);
    check("rst_idx", {28'b0, eng_idx}, 32'd0);
    check_result("rst", 16'd0);
    rst = 1'b1;
    tick();

    set_fixed('{-3, 7, 2, 7, 0, 1, -9, 5, 6, 4});
    run_one(5, 0, 1'b0, -1);
    check("t1_class", {28'b0, res_class}, 32'd1);
    check("t1_score", {21'b0, res_score}, 32'd7);

    set_fixed('{-1024, -1024, -1024, -1024, -1024, -1024, -1024, -1024, -1024, -1});
    run_one(3, 1, 1'b0, -1);
    check("t2_class", {28'b0, res_class}, 32'd9);
    check("t2_score", {21'b0, res_score}, {21'b0, 11'h7FF});
    set_fixed('{-1024, -1024, -1024, -1024, -1024, -1024, -1024, -1024, -1024, -1024});
    run_one(4, 0, 1'b0, -1);
    check("t3_class", {28'b0, res_class}, 32'd0);
    check("t3_score", {21'b0, res_score}, {21'b0, 11'h400});

    run_one(-1, 0, 1'b0, -1);
    check("to_err", {31'b0, res_err}, 32'd1);
    check("to_class", {28'b0, res_class}, 32'hF);
    set_random(1);
    run_one(6, 20, 1'b1, -1);
    set_random(0);
    run_one(3, 0, 1'b0, -1);

    set_random(0);
    run_one(4, 0, 1'b0, 4);
    set_random(1);
    run_one(5, 0, 1'b0, -1);

    set_random(0);
    run_one(T + 2, 0, 1'b0, -1);
    check("late_done_err", {31'b0, res_err}, 32'd0);

    repeat (40) begin
      set_random(int'($urandom_range(0, 1)));
      run_one(($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(3, T + 2)),
              int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), -1);
    end
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
